dct2d_ctrl: RTL and testbench

Sequencer for the 16×16 two-dimensional DCT datapath.
- Walks an image stored as 16-pixel rows in the input memory, one 16×16 block at a time.
- Per block: feeds 16 rows through the row DCT into the transpose buffer, then 16 transposed columns through the column DCT into the output memory.
- Sits in the top level between the input memory, the transpose buffer, the two 1-D DCT stages and the output memory.
- Owns every address, enable and valid strobe on those paths; carries no pixel or coefficient data.

---
 rtl/dct_pkg.sv | 20 ++
 rtl/vld_delay.sv | 26 ++
 rtl/dct2d_ctrl.sv | 171 +++++++++++++++++
 tb/tb_dct2d_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/dct_pkg.sv
// Shared constants for the 16x16 2-D DCT datapath: block geometry, controller states
// and default 1-D stage latencies, so the DCT stages and the sequencer agree.
package dct_pkg;

    localparam int unsigned BLK_SIZE    = 16;
    localparam int unsigned BLK_LOG2    = 4;
    localparam int unsigned ROW_LAT_DEF = 2;
    localparam int unsigned COL_LAT_DEF = 2;
    localparam int unsigned CNT_W       = 5;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StRow    = 3'd1,
        StRdrain = 3'd2,
        StCol    = 3'd3,
        StCdrain = 3'd4,
        StDone   = 3'd5
    } state_e;

endpackage

// File: rtl/vld_delay.sv
// Valid-strobe delay line of DEPTH register stages with synchronous clear.
module vld_delay #(
    parameter int unsigned DEPTH = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] sr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q <= '0;
        end else begin
            sr_q[0] <= din;
            for (int i = 1; i < int'(DEPTH); i++) begin
                sr_q[i] <= sr_q[i-1];
            end
        end
    end

    assign dout = sr_q[DEPTH-1];

endmodule

// File: rtl/dct2d_ctrl.sv
// Sequencer for the 16x16 2-D DCT: walks blocks through row DCT, transpose buffer and
// column DCT, generating every address, enable and valid strobe. Carries no data.
module dct2d_ctrl
    import dct_pkg::*;
#(
    parameter int unsigned N_BLK   = 256,
    parameter int unsigned ROW_LAT = ROW_LAT_DEF,
    parameter int unsigned COL_LAT = COL_LAT_DEF,
    parameter int unsigned ADDR_W  = 12,
    localparam int unsigned BLK_W  = (N_BLK > 1) ? $clog2(N_BLK) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [BLK_W-1:0]  blk_idx,
    output logic              mem_in_re,
    output logic [ADDR_W-1:0] mem_in_addr,
    output logic              row_in_vld,
    output logic              tb_we,
    output logic [3:0]        tb_waddr,
    output logic              tb_re,
    output logic [3:0]        tb_raddr,
    output logic              col_in_vld,
    output logic              mem_out_we,
    output logic [ADDR_W-1:0] mem_out_addr
);

    localparam logic [CNT_W-1:0] LastIdx  = CNT_W'(BLK_SIZE - 1);
    localparam logic [CNT_W-1:0] RowLastC = CNT_W'(ROW_LAT);
    localparam logic [CNT_W-1:0] ColLastC = CNT_W'(COL_LAT);
    localparam logic [BLK_W-1:0] LastBlk  = BLK_W'(N_BLK - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BLK_W-1:0]   blk_q, blk_d;
    logic [BLK_LOG2-1:0] wcnt_q, ocnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            blk_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            blk_q   <= blk_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        blk_d       = blk_q;
        busy        = (state_q != StIdle);
        done        = 1'b0;
        mem_in_re   = 1'b0;
        mem_in_addr = '0;
        tb_re       = 1'b0;
        tb_raddr    = '0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRow;
                    cnt_d   = '0;
                    blk_d   = '0;
                end
            end
            StRow: begin
                mem_in_re   = 1'b1;
                // Block base is formed by concatenation; the block index owns the upper bits.
                mem_in_addr = ADDR_W'({blk_q, cnt_q[BLK_LOG2-1:0]});
                if (cnt_q == LastIdx) begin
                    state_d = StRdrain;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StRdrain: begin
                if (cnt_q == RowLastC) begin
                    state_d = StCol;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StCol: begin
                tb_re    = 1'b1;
                tb_raddr = cnt_q[BLK_LOG2-1:0];
                if (cnt_q == LastIdx) begin
                    state_d = StCdrain;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StCdrain: begin
                if (cnt_q == ColLastC) begin
                    cnt_d = '0;
                    if (blk_q == LastBlk) begin
                        state_d = StDone;
                    end else begin
                        state_d = StRow;
                        blk_d   = blk_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Strobe pipelines track the datapath latencies independently of the FSM.
    vld_delay #(.DEPTH(1)) u_dl_row (
        .clk  (clk),
        .rst  (rst),
        .din  (mem_in_re),
        .dout (row_in_vld)
    );

    vld_delay #(.DEPTH(ROW_LAT)) u_dl_tbw (
        .clk  (clk),
        .rst  (rst),
        .din  (row_in_vld),
        .dout (tb_we)
    );

    vld_delay #(.DEPTH(1)) u_dl_col (
        .clk  (clk),
        .rst  (rst),
        .din  (tb_re),
        .dout (col_in_vld)
    );

    vld_delay #(.DEPTH(COL_LAT)) u_dl_out (
        .clk  (clk),
        .rst  (rst),
        .din  (col_in_vld),
        .dout (mem_out_we)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt_q <= '0;
            ocnt_q <= '0;
        end else begin
            if (tb_we) begin
                wcnt_q <= wcnt_q + 1'b1;
            end
            if (mem_out_we) begin
                ocnt_q <= ocnt_q + 1'b1;
            end
        end
    end

    assign tb_waddr     = wcnt_q;
    assign blk_idx      = blk_q;
    // blk only advances after the last output word, so it still names the draining block.
    assign mem_out_addr = ADDR_W'({blk_q, ocnt_q});

endmodule

// File: tb/tb_dct2d_ctrl.sv
// Directed bench: three controller configurations checked cycle by cycle against a
// hand-derived timing model of the block schedule.
module tb_dct2d_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [2:0] start;

    logic        busy_a, done_a, mir_a, riv_a, tbw_a, tbr_a, civ_a, mow_a;
    logic [0:0]  blk_a;
    logic [11:0] mia_a, moa_a;
    logic [3:0]  twa_a, tra_a;

    logic        busy_b, done_b, mir_b, riv_b, tbw_b, tbr_b, civ_b, mow_b;
    logic [1:0]  blk_b;
    logic [11:0] mia_b, moa_b;
    logic [3:0]  twa_b, tra_b;

    logic        busy_c, done_c, mir_c, riv_c, tbw_c, tbr_c, civ_c, mow_c;
    logic [0:0]  blk_c;
    logic [11:0] mia_c, moa_c;
    logic [3:0]  twa_c, tra_c;

    dct2d_ctrl #(.N_BLK(1), .ROW_LAT(2), .COL_LAT(2), .ADDR_W(12)) u_a (
        .clk(clk), .rst(rst), .start(start[0]), .busy(busy_a), .done(done_a),
        .blk_idx(blk_a), .mem_in_re(mir_a), .mem_in_addr(mia_a), .row_in_vld(riv_a),
        .tb_we(tbw_a), .tb_waddr(twa_a), .tb_re(tbr_a), .tb_raddr(tra_a),
        .col_in_vld(civ_a), .mem_out_we(mow_a), .mem_out_addr(moa_a)
    );

    dct2d_ctrl #(.N_BLK(4), .ROW_LAT(2), .COL_LAT(2), .ADDR_W(12)) u_b (
        .clk(clk), .rst(rst), .start(start[1]), .busy(busy_b), .done(done_b),
        .blk_idx(blk_b), .mem_in_re(mir_b), .mem_in_addr(mia_b), .row_in_vld(riv_b),
        .tb_we(tbw_b), .tb_waddr(twa_b), .tb_re(tbr_b), .tb_raddr(tra_b),
        .col_in_vld(civ_b), .mem_out_we(mow_b), .mem_out_addr(moa_b)
    );

    dct2d_ctrl #(.N_BLK(2), .ROW_LAT(1), .COL_LAT(5), .ADDR_W(12)) u_c (
        .clk(clk), .rst(rst), .start(start[2]), .busy(busy_c), .done(done_c),
        .blk_idx(blk_c), .mem_in_re(mir_c), .mem_in_addr(mia_c), .row_in_vld(riv_c),
        .tb_we(tbw_c), .tb_waddr(twa_c), .tb_re(tbr_c), .tb_raddr(tra_c),
        .col_in_vld(civ_c), .mem_out_we(mow_c), .mem_out_addr(moa_c)
    );

    logic [7:0]  obs_s   [3];
    logic [31:0] obs_ia  [3];
    logic [31:0] obs_wa  [3];
    logic [31:0] obs_ra  [3];
    logic [31:0] obs_oa  [3];
    logic [31:0] obs_blk [3];

    assign obs_s[0]   = {busy_a, done_a, mir_a, riv_a, tbw_a, tbr_a, civ_a, mow_a};
    assign obs_s[1]   = {busy_b, done_b, mir_b, riv_b, tbw_b, tbr_b, civ_b, mow_b};
    assign obs_s[2]   = {busy_c, done_c, mir_c, riv_c, tbw_c, tbr_c, civ_c, mow_c};
    assign obs_ia[0]  = {20'd0, mia_a};
    assign obs_ia[1]  = {20'd0, mia_b};
    assign obs_ia[2]  = {20'd0, mia_c};
    assign obs_oa[0]  = {20'd0, moa_a};
    assign obs_oa[1]  = {20'd0, moa_b};
    assign obs_oa[2]  = {20'd0, moa_c};
    assign obs_wa[0]  = {28'd0, twa_a};
    assign obs_wa[1]  = {28'd0, twa_b};
    assign obs_wa[2]  = {28'd0, twa_c};
    assign obs_ra[0]  = {28'd0, tra_a};
    assign obs_ra[1]  = {28'd0, tra_b};
    assign obs_ra[2]  = {28'd0, tra_c};
    assign obs_blk[0] = {31'd0, blk_a};
    assign obs_blk[1] = {30'd0, blk_b};
    assign obs_blk[2] = {31'd0, blk_c};

    int rl_t [3] = '{2, 2, 1};
    int cl_t [3] = '{2, 2, 5};
    int nb_t [3] = '{1, 4, 2};
    int base [3];
    bit active [3];

    int k;
    int n_chk  = 0;
    int n_pass = 0;
    int exp_ob = 0;
    int done_b_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, k, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Expected strobes for cycle kr after the accepting edge (kr=0 means idle).
    // s = {busy, done, mem_in_re, row_in_vld, tb_we, tb_re, col_in_vld, mem_out_we}
    task automatic model(input int i, input int kr, output logic [7:0] s,
                         output int ia, output int wa, output int ra, output int oa,
                         output int blk, output bit in_pass);
        int rl, cl, p, last, b, j;
        rl = rl_t[i];
        cl = cl_t[i];
        p = 34 + rl + cl;
        last = p * nb_t[i];
        s = '0;
        ia = 0; wa = 0; ra = 0; oa = 0; blk = 0; in_pass = 1'b0;
        if (kr >= 1 && kr <= last) begin
            b = (kr - 1) / p;
            j = (kr - 1) % p;
            in_pass = 1'b1;
            blk  = b;
            s[7] = 1'b1;
            s[5] = (j < 16);
            ia   = b * 16 + j;
            s[4] = (j >= 1 && j <= 16);
            s[3] = (j >= 1 + rl && j <= 16 + rl);
            wa   = j - 1 - rl;
            s[2] = (j >= 17 + rl && j <= 32 + rl);
            ra   = j - 17 - rl;
            s[1] = (j >= 18 + rl && j <= 33 + rl);
            s[0] = (j >= 18 + rl + cl && j <= 33 + rl + cl);
            oa   = b * 16 + j - 18 - rl - cl;
        end else if (kr == last + 1) begin
            s[7] = 1'b1;
            s[6] = 1'b1;
        end
    endtask

    initial begin
        logic [7:0] s;
        int ia, wa, ra, oa, blk, kr;
        bit in_pass;

        rst   = 1'b1;
        start = '0;
        k     = 0;
        for (int i = 0; i < 3; i++) begin
            active[i] = 1'b0;
            base[i]   = 0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_strb%0d", i), {24'd0, obs_s[i]}, 32'd0);
            check($sformatf("rst_blk%0d", i), obs_blk[i], 32'd0);
            check($sformatf("rst_oaddr%0d", i), obs_oa[i], 32'd0);
        end
        rst = 1'b0;

        for (k = 1; k <= 310; k++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                kr = active[i] ? (k - base[i]) : 0;
                model(i, kr, s, ia, wa, ra, oa, blk, in_pass);
                check($sformatf("strb%0d", i), {24'd0, obs_s[i]}, {24'd0, s});
                if (s[5]) check($sformatf("in_addr%0d", i), obs_ia[i], ia);
                if (s[3]) check($sformatf("tb_waddr%0d", i), obs_wa[i], wa);
                if (s[2]) check($sformatf("tb_raddr%0d", i), obs_ra[i], ra);
                if (s[0]) check($sformatf("out_addr%0d", i), obs_oa[i], oa);
                if (in_pass) check($sformatf("blk_idx%0d", i), obs_blk[i], blk);
            end

            // Independent scoreboard for the 4-block first pass: contiguous 0..63.
            if (k <= 160) begin
                if (mow_b) begin
                    check("b_out_seq", obs_oa[1], exp_ob);
                    exp_ob++;
                end
                if (done_b) done_b_cnt++;
            end
            if (k == 160) begin
                check("b_out_words", exp_ob, 64);
                check("b_done_count", done_b_cnt, 1);
            end

            start = '0;
            rst   = 1'b0;
            case (k)
                5: begin
                    start = 3'b111;
                    for (int i = 0; i < 3; i++) begin
                        active[i] = 1'b1;
                        base[i]   = 5;
                    end
                end
                45: begin
                    start[0] = 1'b1;
                    base[0]  = 45;
                end
                63: start[1] = 1'b1;
                165: begin
                    start[1] = 1'b1;
                    base[1]  = 165;
                end
                285: begin
                    rst = 1'b1;
                    for (int i = 0; i < 3; i++) active[i] = 1'b0;
                end
                288: begin
                    start[1]  = 1'b1;
                    active[1] = 1'b1;
                    base[1]   = 288;
                end
                default: ;
            endcase
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
